// File: rtl/multiplicador_taps.sv
// Tap-product generator feeding acumulador: keeps the last NTAPS samples and streams coef[i]*x[n-i], one per clock.
// Define MULT_SAT_EN to saturate out-of-range products instead of wrapping them.
module multiplicador_taps #(
    parameter int                  NTAPS = 4,
    parameter int                  W     = 25,
    parameter int                  FRAC  = 23,
    parameter logic [NTAPS*W-1:0]  COEFS = {25'h0080000, 25'h0100000, 25'h0200000, 25'h0400000}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] x_in,
    input  logic         muestra_valida,
    output logic [W-1:0] prod,
    output logic         prod_valido,
    output logic         listo,
    output logic         ocupado,
    output logic         estado_o
);

    localparam int IW = (NTAPS > 1) ? $clog2(NTAPS) : 1;

    typedef enum logic {IDLE = 1'b0, CALC = 1'b1} estado_t;

    // Handshake: a sample is taken on any edge where muestra_valida=1 and ocupado=0; there is no backpressure
    // beyond ocupado, so samples offered while ocupado=1 are simply dropped. prod is meaningful only when prod_valido=1.
    estado_t        state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [W-1:0]   d_q [NTAPS];
    logic [W-1:0]   d_d [NTAPS];
    logic [W-1:0]   prod_q, prod_d;
    logic           prod_valido_q, prod_valido_d;
    logic           listo_q, listo_d;
    logic           ocupado_q, ocupado_d;

    logic [W-1:0]          coef_sel;
    logic [W-1:0]          d_sel;
    logic signed [2*W-1:0] full;
    logic [W-1:0]          prod_calc;
    logic                  last_tap;

    assign coef_sel = COEFS[int'(idx_q)*W +: W];
    assign d_sel    = d_q[idx_q];
    assign full     = $signed(coef_sel) * $signed(d_sel);
    assign last_tap = (idx_q == IW'(NTAPS - 1));

`ifdef MULT_SAT_EN
    logic signed [2*W-1:0] shifted;
    assign shifted = full >>> FRAC;

    // In range only when every bit above the W-bit sign position matches the sign.
    always_comb begin
        prod_calc = shifted[W-1:0];
        if (shifted[2*W-1:W-1] != {(W+1){shifted[2*W-1]}}) begin
            prod_calc = shifted[2*W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end
`else
    assign prod_calc = W'(full >>> FRAC);
`endif

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        d_d           = d_q;
        prod_d        = prod_q;
        prod_valido_d = 1'b0;
        listo_d       = 1'b0;
        ocupado_d     = ocupado_q;
        case (state_q)
            IDLE: begin
                ocupado_d = 1'b0;
                if (muestra_valida) begin
                    d_d[0] = x_in;
                    for (int k = 1; k < NTAPS; k++) begin
                        d_d[k] = d_q[k-1];
                    end
                    idx_d     = '0;
                    state_d   = CALC;
                    ocupado_d = 1'b1;
                end
            end
            CALC: begin
                prod_d        = prod_calc;
                prod_valido_d = 1'b1;
                listo_d       = last_tap;
                idx_d         = idx_q + IW'(1);
                if (last_tap) begin
                    idx_d     = '0;
                    state_d   = IDLE;
                    ocupado_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            prod_q        <= '0;
            prod_valido_q <= 1'b0;
            listo_q       <= 1'b0;
            ocupado_q     <= 1'b0;
            for (int k = 0; k < NTAPS; k++) begin
                d_q[k] <= '0;
            end
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            prod_q        <= prod_d;
            prod_valido_q <= prod_valido_d;
            listo_q       <= listo_d;
            ocupado_q     <= ocupado_d;
            d_q           <= d_d;
        end
    end

    assign prod        = prod_q;
    assign prod_valido = prod_valido_q;
    assign listo       = listo_q;
    assign ocupado     = ocupado_q;
    assign estado_o    = state_q;

endmodule

// File: tb/tb_multiplicador_taps.sv
// Bench for multiplicador_taps: transaction-level model with per-cycle compare, plus literal frame checks.
// Honours MULT_SAT_EN the same way as the design.
module tb_multiplicador_taps;

    localparam int NTAPS = 4;
    localparam int W     = 25;
    localparam int FRAC  = 23;

`ifdef MULT_SAT_EN
    localparam logic [W-1:0] EXP6 = 25'h0FFFFFF;
`else
    localparam logic [W-1:0] EXP6 = 25'h0000000;
`endif

    logic         clk = 1'b0;
    logic         rst, mv, mv6;
    logic [W-1:0] x_in, x6, prod, prod6;
    logic         pv, li, oc, est, pv6, li6, oc6, est6;

    always #5 clk = ~clk;

    multiplicador_taps dut (
        .clk(clk), .rst(rst), .x_in(x_in), .muestra_valida(mv),
        .prod(prod), .prod_valido(pv), .listo(li), .ocupado(oc), .estado_o(est)
    );

    multiplicador_taps #(
        .COEFS({25'h0080000, 25'h0100000, 25'h0200000, 25'h1000000})
    ) dut6 (
        .clk(clk), .rst(rst), .x_in(x6), .muestra_valida(mv6),
        .prod(prod6), .prod_valido(pv6), .listo(li6), .ocupado(oc6), .estado_o(est6)
    );

    int checks = 0;
    int errors = 0;

    // tap0..tap3 of the default build: 0.5, 0.25, 0.125, 0.0625
    logic [W-1:0] coef_m [NTAPS] = '{25'h0400000, 25'h0200000, 25'h0100000, 25'h0080000};

    logic [W-1:0] dl[$];
    logic [W-1:0] exp_q[$];
    logic         val_q[$];
    logic         lst_q[$];
    logic         ocu_q[$];
    logic [W-1:0] mdl_log[$];
    logic [W-1:0] last_prod;
    bit           armed = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] mdl_prod(input logic [W-1:0] c, input logic [W-1:0] x);
        longint p;
        p = (longint'($signed(c)) * longint'($signed(x))) >>> FRAC;
`ifdef MULT_SAT_EN
        if (p > longint'(2**(W-1) - 1)) return {1'b0, {(W-1){1'b1}}};
        if (p < -longint'(2**(W-1)))    return {1'b1, {(W-1){1'b0}}};
`endif
        return W'(p);
    endfunction

    // Each queue entry is what the outputs must show in one future cycle.
    always @(negedge clk) begin
        logic [W-1:0] e_prod;
        logic         e_val, e_lst, e_ocu;
        if (armed) begin
            if (val_q.size() > 0) begin
                e_val  = val_q.pop_front();
                e_prod = exp_q.pop_front();
                e_lst  = lst_q.pop_front();
                e_ocu  = ocu_q.pop_front();
                if (e_val) begin
                    last_prod = e_prod;
                    mdl_log.push_back(e_prod);
                end else begin
                    e_prod = last_prod;
                end
            end else begin
                e_val  = 1'b0;
                e_lst  = 1'b0;
                e_ocu  = 1'b0;
                e_prod = last_prod;
            end
            chk("prod_valido", W'(pv), W'(e_val));
            chk("listo", W'(li), W'(e_lst));
            chk("ocupado", W'(oc), W'(e_ocu));
            chk("prod", prod, e_prod);
        end
        if (rst) begin
            armed     = 1'b1;
            last_prod = '0;
            dl.delete();
            for (int i = 0; i < NTAPS; i++) dl.push_back('0);
            exp_q.delete(); val_q.delete(); lst_q.delete(); ocu_q.delete();
        end else if (armed && val_q.size() == 0 && mv) begin
            dl.push_front(x_in);
            void'(dl.pop_back());
            val_q.push_back(1'b0); exp_q.push_back('0); lst_q.push_back(1'b0); ocu_q.push_back(1'b1);
            for (int i = 0; i < NTAPS; i++) begin
                val_q.push_back(1'b1);
                exp_q.push_back(mdl_prod(coef_m[i], dl[i]));
                lst_q.push_back(i == NTAPS - 1);
                ocu_q.push_back(i != NTAPS - 1);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] x);
        mv   = 1'b1;
        x_in = x;
        step();
        mv   = 1'b0;
    endtask

    task automatic chk_frame(input string name, input int base,
                             input logic [W-1:0] a0, input logic [W-1:0] a1,
                             input logic [W-1:0] a2, input logic [W-1:0] a3);
        logic [W-1:0] lit [NTAPS];
        lit = '{a0, a1, a2, a3};
        for (int i = 0; i < NTAPS; i++) begin
            if (base + i < mdl_log.size()) chk(name, mdl_log[base + i], lit[i]);
            else chk({name, "_missing"}, '0, lit[i] ^ 25'h1);
        end
    endtask

    initial begin
        int base;
        bit found;
        rst = 1'b1; mv = 1'b0; x_in = '0; mv6 = 1'b0; x6 = '0;
        step(2);
        rst = 1'b0;

        chk("reset_prod", prod, '0);
        chk("reset_valid", W'(pv), '0);
        chk("reset_listo", W'(li), '0);
        chk("reset_ocupado", W'(oc), '0);

        // Frames 1..3 with 1.0 each: delay line fills up one tap at a time
        base = mdl_log.size();
        send(25'h0800000); step(8);
        send(25'h0800000); step(8);
        send(25'h0800000); step(8);
        chk_frame("frame1", base,     25'h0400000, 25'h0000000, 25'h0000000, 25'h0000000);
        chk_frame("frame2", base + 4, 25'h0400000, 25'h0200000, 25'h0000000, 25'h0000000);
        chk_frame("frame3", base + 8, 25'h0400000, 25'h0200000, 25'h0100000, 25'h0000000);

        // Negative sample
        do_reset();
        base = mdl_log.size();
        send(25'h1800000); step(8);
        chk_frame("neg", base, 25'h1C00000, 25'h0000000, 25'h0000000, 25'h0000000);

        // Continuous muestra_valida: one sample per 5 cycles, exactly four frames in 20 cycles
        do_reset();
        base = mdl_log.size();
        mv = 1'b1; x_in = 25'h0800000;
        step(20);
        mv = 1'b0;
        step(8);
        chk_frame("cont_f2", base + 4,  25'h0400000, 25'h0200000, 25'h0000000, 25'h0000000);
        chk_frame("cont_f4", base + 12, 25'h0400000, 25'h0200000, 25'h0100000, 25'h0080000);
        chk("cont_count", W'(mdl_log.size() - base), W'(16));

        // Reset in the second cycle of a frame, then a fresh frame on a cleared delay line
        do_reset();
        send(25'h0800000);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step(2);
        base = mdl_log.size();
        send(25'h0800000); step(8);
        chk_frame("after_rst", base, 25'h0400000, 25'h0000000, 25'h0000000, 25'h0000000);

        // Out-of-range product: -2.0 * -2.0
        chk("model_sat", mdl_prod(25'h1000000, 25'h1000000), EXP6);
        mv6 = 1'b1; x6 = 25'h1000000;
        step();
        mv6 = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (pv6) found = 1'b1;
        end
        chk("sat_wait", W'(found), W'(1));
        if (found) begin
            chk("sat_prod0", prod6, EXP6);
            chk("sat_listo0", W'(li6), '0);
            for (int i = 1; i < NTAPS; i++) begin
                @(negedge clk);
                chk("sat_valid", W'(pv6), W'(1));
                chk("sat_prod", prod6, '0);
                chk("sat_listo", W'(li6), W'(i == NTAPS - 1));
            end
        end
        step(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
